// File: rtl/periph_bus_arbiter_if.sv
// Bundle of both master ports and the peripheral bus around the arbiter.
// "master" is the environment side (masters + peripheral), "slave" is the arbiter.
interface periph_bus_arbiter_if;
    logic        m0_req;
    logic        m0_rd;
    logic        m0_wr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_rd;
    logic        m1_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic [31:0] m1_rdata;

    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        busy;

    modport master (
        output m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        input  m0_gnt, m0_rdata,
        output m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
        input  m1_gnt, m1_rdata,
        input  bus_rd, bus_wr, bus_addr, bus_wdata, busy,
        output bus_rdata
    );

    modport slave (
        input  m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
        output m0_gnt, m0_rdata,
        input  m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
        output m1_gnt, m1_rdata,
        output bus_rd, bus_wr, bus_addr, bus_wdata, busy,
        input  bus_rdata
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus with a bounded burst
// length; grants are registered, the bus path itself is purely combinational.
module periph_bus_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    periph_bus_arbiter_if.slave  bus_if
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           state;
    logic             gnt0;
    logic             gnt1;
    logic             last;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat0;
    logic             beat1;

    assign beat0 = gnt0 & (bus_if.m0_rd | bus_if.m0_wr);
    assign beat1 = gnt1 & (bus_if.m1_rd | bus_if.m1_wr);

    // last==1 means master 1 owned most recently, so master 0 wins the next tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus_if.m0_req && (!bus_if.m1_req || last)) begin
                        state <= OWN0;
                        gnt0  <= 1'b1;
                        gnt1  <= 1'b0;
                    end else if (bus_if.m1_req) begin
                        state <= OWN1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!bus_if.m0_req || (beat0 && beat_cnt == LAST_BEAT && bus_if.m1_req)) begin
                        last     <= 1'b0;
                        beat_cnt <= '0;
                        gnt0     <= 1'b0;
                        gnt1     <= bus_if.m1_req;
                        state    <= bus_if.m1_req ? OWN1 : IDLE;
                    end else if (beat0 && beat_cnt != LAST_BEAT) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                OWN1: begin
                    if (!bus_if.m1_req || (beat1 && beat_cnt == LAST_BEAT && bus_if.m0_req)) begin
                        last     <= 1'b1;
                        beat_cnt <= '0;
                        gnt1     <= 1'b0;
                        gnt0     <= bus_if.m0_req;
                        state    <= bus_if.m0_req ? OWN0 : IDLE;
                    end else if (beat1 && beat_cnt != LAST_BEAT) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.m0_gnt = gnt0;
    assign bus_if.m1_gnt = gnt1;
    assign bus_if.busy   = gnt0 | gnt1;

    // Strobes from a master without the grant never reach the peripheral
    always_comb begin
        bus_if.bus_rd    = 1'b0;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        bus_if.m0_rdata  = '0;
        bus_if.m1_rdata  = '0;
        if (gnt0) begin
            bus_if.bus_rd    = bus_if.m0_rd;
            bus_if.bus_wr    = bus_if.m0_wr;
            bus_if.bus_addr  = bus_if.m0_addr;
            bus_if.bus_wdata = bus_if.m0_wdata;
            bus_if.m0_rdata  = bus_if.bus_rdata;
        end else if (gnt1) begin
            bus_if.bus_rd    = bus_if.m1_rd;
            bus_if.bus_wr    = bus_if.m1_wr;
            bus_if.bus_addr  = bus_if.m1_addr;
            bus_if.bus_wdata = bus_if.m1_wdata;
            bus_if.m1_rdata  = bus_if.bus_rdata;
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against an owner/burst-count reference model of the arbitration rules.
module tb_periph_bus_arbiter;

    localparam int MAX_BURST = 4;

    logic clk;
    logic reset;
    int   num_checks;
    int   num_fails;

    // Reference model: owner -1 = nobody, otherwise the master index
    int owner;
    int last_owner;
    int beats;

    periph_bus_arbiter_if bif ();

    periph_bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic void model_step();
        int req [2];
        int acc [2];
        req[0] = int'(bif.m0_req);
        req[1] = int'(bif.m1_req);
        acc[0] = int'(bif.m0_rd | bif.m0_wr);
        acc[1] = int'(bif.m1_rd | bif.m1_wr);
        if (!reset) begin
            owner = -1; last_owner = 1; beats = 0;
        end else if (owner < 0) begin
            if (req[0] == 1 && req[1] == 1) owner = 1 - last_owner;
            else if (req[0] == 1)           owner = 0;
            else if (req[1] == 1)           owner = 1;
        end else begin
            int other = 1 - owner;
            if (req[owner] == 0) begin
                last_owner = owner; beats = 0;
                owner = (req[other] == 1) ? other : -1;
            end else if (acc[owner] == 1) begin
                if (beats == MAX_BURST - 1 && req[other] == 1) begin
                    last_owner = owner; beats = 0; owner = other;
                end else if (beats < MAX_BURST - 1) begin
                    beats++;
                end
            end
        end
    endfunction

    // One clock: check combinational/registered outputs mid-cycle, then advance the model
    task automatic applyStimulus();
        logic [31:0] e_addr, e_wdata;
        logic        e_rd, e_wr;
        @(negedge clk);
        #1;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
        if (owner == 0) begin
            e_rd = bif.m0_rd; e_wr = bif.m0_wr; e_addr = bif.m0_addr; e_wdata = bif.m0_wdata;
        end else if (owner == 1) begin
            e_rd = bif.m1_rd; e_wr = bif.m1_wr; e_addr = bif.m1_addr; e_wdata = bif.m1_wdata;
        end
        checkOutput("m0_gnt",    32'(bif.m0_gnt),  32'(owner == 0));
        checkOutput("m1_gnt",    32'(bif.m1_gnt),  32'(owner == 1));
        checkOutput("busy",      32'(bif.busy),    32'(owner >= 0));
        checkOutput("bus_rd",    32'(bif.bus_rd),  32'(e_rd));
        checkOutput("bus_wr",    32'(bif.bus_wr),  32'(e_wr));
        checkOutput("bus_addr",  bif.bus_addr,     e_addr);
        checkOutput("bus_wdata", bif.bus_wdata,    e_wdata);
        checkOutput("m0_rdata",  bif.m0_rdata,     (owner == 0) ? bif.bus_rdata : 32'h0);
        checkOutput("m1_rdata",  bif.m1_rdata,     (owner == 1) ? bif.bus_rdata : 32'h0);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_quiet();
        bif.m0_req = 0; bif.m0_rd = 0; bif.m0_wr = 0; bif.m0_addr = '0; bif.m0_wdata = '0;
        bif.m1_req = 0; bif.m1_rd = 0; bif.m1_wr = 0; bif.m1_addr = '0; bif.m1_wdata = '0;
        bif.bus_rdata = '0;
    endtask

    initial begin
        int reads, gaps, w0, w1, max_w0, max_w1;
        bit found;
        num_checks = 0; num_fails = 0;
        owner = -1; last_owner = 1; beats = 0;

        // Reset held with both masters requesting
        reset = 1'b0;
        drive_quiet();
        bif.m0_req = 1; bif.m1_req = 1;
        repeat (3) applyStimulus();
        reset = 1'b1;
        applyStimulus();
        checkOutput("reset_tie_m0_gnt", 32'(bif.m0_gnt), 32'd1);
        checkOutput("reset_tie_m1_gnt", 32'(bif.m1_gnt), 32'd0);

        // Single master write
        drive_quiet();
        applyStimulus();
        bif.m1_req = 1; bif.m1_wr = 1; bif.m1_addr = 32'h4000_000C; bif.m1_wdata = 32'h0000_00A5;
        applyStimulus();
        checkOutput("single_m1_gnt",    32'(bif.m1_gnt), 32'd1);
        checkOutput("single_bus_wr",    32'(bif.bus_wr), 32'd1);
        checkOutput("single_bus_addr",  bif.bus_addr,    32'h4000_000C);
        checkOutput("single_bus_wdata", bif.bus_wdata,   32'h0000_00A5);
        applyStimulus();
        bif.m1_req = 0; bif.m1_wr = 0;
        applyStimulus();
        checkOutput("single_release_busy", 32'(bif.busy), 32'd0);

        // Burst cap: m0 streams reads while m1 waits
        bif.m0_req = 1; bif.m0_rd = 1; bif.m0_addr = 32'h4000_0010;
        applyStimulus();
        bif.m1_req = 1;
        reads = 0; gaps = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bif.m1_gnt) found = 1;
            else begin
                if (bif.m0_gnt && bif.bus_rd && bif.bus_addr == 32'h4000_0010) reads++;
                if (!bif.busy) gaps++;
                applyStimulus();
            end
        end
        checkOutput("burst_handover_seen", 32'(found), 32'd1);
        checkOutput("burst_reads",    32'(reads), 32'd4);
        checkOutput("burst_idle_gap", 32'(gaps),  32'd0);
        checkOutput("burst_m0_gnt",   32'(bif.m0_gnt), 32'd0);

        // m1 releases straight back to m0; then read return and a non-owner write
        bif.m1_req = 0;
        applyStimulus();
        bif.m0_addr = 32'h4000_0000; bif.bus_rdata = 32'h1234_5678;
        bif.m1_wr = 1; bif.m1_addr = 32'h4000_0014; bif.m1_wdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("rdret_m0_rdata", bif.m0_rdata, 32'h1234_5678);
        checkOutput("rdret_m1_rdata", bif.m1_rdata, 32'h0);
        checkOutput("nonowner_addr",  bif.bus_addr, 32'h4000_0000);
        checkOutput("nonowner_wr",    32'(bif.bus_wr), 32'd0);
        applyStimulus();

        // Fairness under continuous contention
        drive_quiet();
        applyStimulus();
        applyStimulus();
        bif.m0_req = 1; bif.m0_rd = 1; bif.m0_addr = 32'h4000_0004;
        bif.m1_req = 1; bif.m1_wr = 1; bif.m1_addr = 32'h4000_0008;
        w0 = 0; w1 = 0; max_w0 = 0; max_w1 = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            w0 = bif.m0_gnt ? 0 : w0 + 1;
            w1 = bif.m1_gnt ? 0 : w1 + 1;
            if (w0 > max_w0) max_w0 = w0;
            if (w1 > max_w1) max_w1 = w1;
        end
        checkOutput("fair_m0_wait_ok", 32'(max_w0 <= 5), 32'd1);
        checkOutput("fair_m1_wait_ok", 32'(max_w1 <= 5), 32'd1);

        // Randomized traffic, occasional mid-burst reset
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 49) != 0);
            bif.m0_req   = ($urandom_range(0, 3) != 0);
            bif.m1_req   = ($urandom_range(0, 3) != 0);
            bif.m0_rd    = 1'($urandom_range(0, 1));
            bif.m0_wr    = 1'($urandom_range(0, 1));
            bif.m1_rd    = 1'($urandom_range(0, 1));
            bif.m1_wr    = 1'($urandom_range(0, 1));
            bif.m0_addr  = 32'h4000_0000 | 32'($urandom_range(0, 255));
            bif.m1_addr  = 32'h4000_0000 | 32'($urandom_range(0, 255));
            bif.m0_wdata = $urandom;
            bif.m1_wdata = $urandom;
            bif.bus_rdata = $urandom;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single memory-mapped peripheral bus (rd/wr/addr/wdata/rdata) between two masters: m0 is the CPU data port, m1 is a DMA/serial-move engine.
- Round-robin arbitration with a bounded burst length, so neither master can starve the other.
- Sits between the masters and the peripheral block (timer, LED, switch, digit and UART registers at 0x4000_00xx).
- The peripheral returns read data combinationally, so every granted access completes in the cycle it is presented.

Parameters:
MAX_BURST, 4, maximum accesses an owner performs while the other master is waiting; legal range 1..15.
CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
m0_req  input  1  master 0 requests the bus; held until it is done
m0_rd  input  1  master 0 read strobe; honoured only while m0_gnt=1
m0_wr  input  1  master 0 write strobe; honoured only while m0_gnt=1
m0_addr  input  32  master 0 byte address
m0_wdata  input  32  master 0 write data
m0_gnt  output  1  registered grant to master 0
m0_rdata  output  32  read data to master 0
m1_req, m1_rd, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rdata  same as m0_*, for master 1
bus_rd  output  1  read strobe to the peripheral
bus_wr  output  1  write strobe to the peripheral
bus_addr  output  32  address to the peripheral
bus_wdata  output  32  write data to the peripheral
bus_rdata  input  32  combinational read data from the peripheral
busy  output  1  1 while either grant is asserted

Behaviour:
- Reset (reset=0 at a rising clk edge):
  - state=IDLE, m0_gnt=m1_gnt=0, beat_cnt=0, last=1 (so m0 wins the first tie).
  - All bus outputs are 0 through the combinational path.
  - Reset asserted mid-burst drops the grant on that edge; an access presented in that same cycle still reaches the bus.
- States: IDLE, OWN0, OWN1. m0_gnt = (state==OWN0); m1_gnt = (state==OWN1). Both grants are direct flop outputs.
- IDLE transitions:
  - Both requesting: go to OWN of the master that is not `last`.
  - Only one requesting: go to that master's OWN.
  - Neither requesting: stay.
  - Grant latency is exactly 1 cycle from the edge at which the request is sampled.
- OWNi, evaluated each edge; `other` = the opposite master, `beat` = gnt_i & (rd_i|wr_i):
  - req_i=0: release. Go to OWN(other) if other's req=1, else IDLE. Set last=i, beat_cnt=0.
  - beat=1, beat_cnt==MAX_BURST-1, other's req=1: hand over to OWN(other). Set last=i, beat_cnt=0. The beat in this cycle completes first.
  - Otherwise: stay; beat_cnt increments on a beat.
  - beat_cnt saturates at MAX_BURST-1 while the other master is idle, so ownership continues.
- Handover goes directly OWN0<->OWN1 with no IDLE bubble.
- Bus mux (combinational):
  - OWNi: bus_* = mi_* and mi_rdata = bus_rdata; the non-owner's rdata is 0.
  - IDLE: bus_rd=bus_wr=0, bus_addr=0, bus_wdata=0, both rdata=0.
  - rd/wr from a non-granted master are ignored and never reach the bus.
- If the owner asserts rd and wr together, both are passed through unchanged; the peripheral resolves them.
- The arbiter adds no extra latency: a read issued in a granted cycle returns data in that same cycle.
- busy = m0_gnt | m1_gnt.

Test Plan:
- Reset: hold reset=0 for 3 cycles with m0_req=m1_req=1 -> both gnt=0 and bus_rd=bus_wr=0 during reset; the edge after release gives m0_gnt=1 (tie to m0).
- Single master: m1_req=1 with m1_wr=1, m1_addr=0x4000000C, m1_wdata=0xA5 -> m1_gnt=1 one cycle later; bus_wr=1, bus_addr=0x4000000C, bus_wdata=0xA5 in that cycle; m1 drops req -> IDLE on the next edge.
- Burst cap: m0 owns and issues continuous reads of 0x40000010, m1_req=1 throughout, MAX_BURST=4 -> exactly 4 reads on the bus, then m1_gnt=1 on the following cycle with no idle gap, and m0_gnt=0.
- Round-robin fairness: both requesting with continuous accesses for 40 cycles -> grants alternate in blocks of 4 beats, and neither master goes more than 5 cycles without a grant.
- Read return: owner m0 reads 0x40000000 while bus_rdata=0x12345678 -> m0_rdata=0x12345678 in the same cycle and m1_rdata=0.
- Non-owner strobe: m0 owns, and m1 asserts m1_wr=1 to 0x40000014 without m1_gnt -> bus_addr/bus_wr follow m0 only; no write to 0x40000014 is seen on the bus.
